bus_rx_queue: RTL and testbench

Parametrised successor to the single-transaction serial bus receiver. Deserialises address+data frames arriving over a narrow bus during a `send` window and classifies each frame as read or write. Completed frames are pushed into a DEPTH-entry FIFO and presented downstream with a valid/ready handshake. Frames that are short, too long, or arrive while the FIFO is full are flagged. Sits between the link sender and the cache/memory request port.

---
 rtl/bus_rx_queue.sv | 143 ++++++++++++++
 tb/tb_bus_rx_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rx_queue.sv
// Serial bus frame receiver with a DEPTH-entry request FIFO and valid/ready output.
// Optional per-beat even parity checking is enabled by defining BUS_RX_PARITY_EN.
module bus_rx_queue #(
    parameter int BUS_W  = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       send,
    input  logic                       write_in,
    input  logic [BUS_W-1:0]           bus,
`ifdef BUS_RX_PARITY_EN
    input  logic                       bus_par,
    output logic                       err_parity,
`endif
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [ADDR_W-1:0]          addr_out,
    output logic [DATA_W-1:0]          data_out,
    output logic                       write,
    output logic                       read,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       err_short,
    output logic                       err_overrun,
    output logic                       err_drop
);

    localparam int FRAME_W = ADDR_W + DATA_W;
    localparam int BEATS   = (FRAME_W + BUS_W - 1) / BUS_W;
    localparam int SR_W    = BEATS * BUS_W;
    localparam int PTR_W   = $clog2(BEATS + 1);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int AW      = $clog2(DEPTH);

    logic [PTR_W-1:0]   ptr;
    logic [SR_W-1:0]    sr;
    logic [FRAME_W-1:0] frame;
    logic               frame_bad;
    logic               at_end, capture, commit, pop, space, push;

    logic [ADDR_W-1:0]  addr_mem [DEPTH];
    logic [DATA_W-1:0]  data_mem [DEPTH];
    logic               op_mem   [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;

    assign frame     = sr[FRAME_W-1:0];
    assign out_valid = (count != '0);
    assign full      = (count == CNT_W'(DEPTH));

    always_comb begin
        at_end  = (ptr == PTR_W'(BEATS));
        capture = send && !at_end;
        commit  = !send && (ptr != '0);
        pop     = out_valid && out_ready;
        // a pop on the commit edge frees a slot even when full
        space   = !full || pop;
        push    = commit && at_end && space && !frame_bad;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
            sr  <= '0;
        end else if (commit) begin
            ptr <= '0;
            sr  <= '0;
        end else if (capture) begin
            sr[ptr*BUS_W +: BUS_W] <= bus;
            ptr                    <= ptr + 1'b1;
        end
    end

`ifdef BUS_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_bad  <= 1'b0;
            err_parity <= 1'b0;
        end else begin
            err_parity <= commit && frame_bad;
            if (commit)
                frame_bad <= 1'b0;
            else if (capture && (bus_par != ^bus))
                frame_bad <= 1'b1;
        end
    end
`else
    assign frame_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_short   <= 1'b0;
            err_overrun <= 1'b0;
            err_drop    <= 1'b0;
        end else begin
            err_short   <= commit && !at_end && !frame_bad;
            err_overrun <= send && at_end;
            err_drop    <= commit && at_end && !space && !frame_bad;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // storage needs no reset: entries are only visible while counted
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= frame[FRAME_W-1:DATA_W];
            data_mem[wr_ptr] <= frame[DATA_W-1:0];
            op_mem[wr_ptr]   <= write_in;
        end
    end

    always_comb begin
        addr_out = '0;
        data_out = '0;
        write    = 1'b0;
        read     = 1'b0;
        if (out_valid) begin
            addr_out = addr_mem[rd_ptr];
            data_out = data_mem[rd_ptr];
            write    = op_mem[rd_ptr];
            read     = !op_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_bus_rx_queue.sv
// Directed testbench for bus_rx_queue with default parameters (6 beats per frame, DEPTH 4).
// Define BUS_RX_PARITY_EN to also exercise the parity option.
module tb_bus_rx_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        send;
    logic        write_in;
    logic [7:0]  bus;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] addr_out;
    logic [31:0] data_out;
    logic        write;
    logic        read;
    logic [2:0]  count;
    logic        full;
    logic        err_short;
    logic        err_overrun;
    logic        err_drop;
`ifdef BUS_RX_PARITY_EN
    logic        bus_par;
    logic        err_parity;
`endif

    int checks = 0;
    int errors = 0;
    int flip_idx = -1;
    int ovr_cnt = 0, short_cnt = 0, drop_cnt = 0;

    bus_rx_queue #(.BUS_W(8), .ADDR_W(16), .DATA_W(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .send(send), .write_in(write_in), .bus(bus),
`ifdef BUS_RX_PARITY_EN
        .bus_par(bus_par), .err_parity(err_parity),
`endif
        .out_ready(out_ready), .out_valid(out_valid), .addr_out(addr_out),
        .data_out(data_out), .write(write), .read(read), .count(count), .full(full),
        .err_short(err_short), .err_overrun(err_overrun), .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_overrun) ovr_cnt++;
        if (err_short)   short_cnt++;
        if (err_drop)    drop_cnt++;
    end

    // Beats come from {addr,data} LSB first; beats past 6 carry 0xEE.
    task automatic drive_frame(input logic [15:0] a, input logic [31:0] d, input int n, input logic w);
        logic [63:0] f;
        f = {16'hEEEE, a, d};
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            send = 1'b1; bus = f[i*8 +: 8]; write_in = ~w;
`ifdef BUS_RX_PARITY_EN
            bus_par = (^f[i*8 +: 8]) ^ (i == flip_idx);
`endif
        end
        @(negedge clk);
        send = 1'b0; write_in = w; bus = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0; send = 1'b0; write_in = 1'b0; bus = '0; out_ready = 1'b0;
`ifdef BUS_RX_PARITY_EN
        bus_par = 1'b0;
`endif
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", out_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if ({addr_out, data_out} !== 48'h0) begin errors++; $display("FAIL reset_fields got %0h exp 0", {addr_out, data_out}); end
        checks++; if ({write, read, full, err_short, err_overrun, err_drop} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 000000", {write, read, full, err_short, err_overrun, err_drop}); end
`ifdef BUS_RX_PARITY_EN
        checks++; if (err_parity !== 1'b0) begin errors++; $display("FAIL reset_parity got %0h exp 0", err_parity); end
`endif
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_write_frame();
        drive_frame(16'hABCD, 32'h11223344, 6, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wr_latency got %0h exp 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wr_valid got %0h exp 1", out_valid); end
        checks++; if (addr_out !== 16'hABCD) begin errors++; $display("FAIL wr_addr got %0h exp abcd", addr_out); end
        checks++; if (data_out !== 32'h11223344) begin errors++; $display("FAIL wr_data got %0h exp 11223344", data_out); end
        checks++; if ({write, read} !== 2'b10) begin errors++; $display("FAIL wr_op got %b exp 10", {write, read}); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL wr_count got %0d exp 1", count); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL wr_pop got count %0d valid %0h exp 0 0", count, out_valid); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL wr_empty_data got %0h exp 0", data_out); end
    endtask

    task automatic test_short_overrun();
        int s0, o0;
        s0 = short_cnt; o0 = ovr_cnt;
        drive_frame(16'h5555, 32'h66666666, 4, 1'b1);
        @(negedge clk);
        checks++; if (err_short !== 1'b1) begin errors++; $display("FAIL short_pulse got %0h exp 1", err_short); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL short_count got %0d exp 0", count); end
        @(negedge clk);
        checks++; if (err_short !== 1'b0) begin errors++; $display("FAIL short_one_cycle got %0h exp 0", err_short); end
        drive_frame(16'h1234, 32'hDEADBEEF, 7, 1'b1);
        @(negedge clk);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL ovr_count got %0d exp 1", count); end
        checks++; if ({addr_out, data_out} !== 48'h1234DEADBEEF) begin
            errors++; $display("FAIL ovr_fields got %0h exp 1234deadbeef", {addr_out, data_out}); end
        checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulses got %0d exp 1", ovr_cnt - o0); end
        checks++; if (short_cnt - s0 !== 1) begin errors++; $display("FAIL short_pulses got %0d exp 1", short_cnt - s0); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_fill_drop();
        int d0;
        d0 = drop_cnt;
        for (int i = 0; i < 4; i++) drive_frame(16'h1000 + 16'(i), 32'hA0000000 + 32'(i), 6, 1'b0);
        @(negedge clk);
        checks++; if (full !== 1'b1 || count !== 3'd4) begin
            errors++; $display("FAIL fill_full got full %0h count %0d exp 1 4", full, count); end
        drive_frame(16'h1FFF, 32'hAFFFFFFF, 6, 1'b0);
        @(negedge clk);
        checks++; if (err_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse got %0h exp 1", err_drop); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL drop_count got %0d exp 4", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (addr_out !== 16'h1000 + 16'(i) || data_out !== 32'hA0000000 + 32'(i) || read !== 1'b1) begin
                errors++; $display("FAIL drain_%0d got %0h %0h rd %0h exp %0h %0h 1", i, addr_out, data_out, read,
                                   16'h1000 + 16'(i), 32'hA0000000 + 32'(i)); end
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", count); end
        checks++; if (drop_cnt - d0 !== 1) begin errors++; $display("FAIL drop_pulses got %0d exp 1", drop_cnt - d0); end
    endtask

    task automatic test_push_pop_full();
        for (int i = 0; i < 4; i++) drive_frame(16'h2000 + 16'(i), 32'hB0 + 32'(i), 6, 1'b1);
        @(negedge clk);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL pp_fill got %0d exp 4", count); end
        drive_frame(16'h2004, 32'hB4, 6, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL pp_nodrop got %0h exp 0", err_drop); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL pp_count got %0d exp 4", count); end
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            checks++; if (addr_out !== 16'h2000 + 16'(i) || data_out !== 32'hB0 + 32'(i) || write !== (i != 4)) begin
                errors++; $display("FAIL pp_order_%0d got %0h %0h wr %0h exp %0h %0h %0h", i, addr_out, data_out, write,
                                   16'h2000 + 16'(i), 32'hB0 + 32'(i), (i != 4)); end
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL pp_empty got %0d exp 0", count); end
    endtask

    task automatic test_async_reset();
        int s0;
        for (int i = 0; i < 2; i++) drive_frame(16'h3000 + 16'(i), 32'hC0 + 32'(i), 6, 1'b1);
        @(negedge clk);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL ar_pre_count got %0d exp 2", count); end
        s0 = short_cnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            send = 1'b1; bus = 8'(8'h71 + i);
        end
        @(posedge clk);
        #2;
        send = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL ar_clear got count %0d valid %0h exp 0 0", count, out_valid); end
        checks++; if ({addr_out, data_out, write, read} !== 50'h0) begin
            errors++; $display("FAIL ar_fields got %0h exp 0", {addr_out, data_out, write, read}); end
        @(negedge clk);
        reset = 1'b1;
        drive_frame(16'h5A5A, 32'h0BADF00D, 6, 1'b1);
        @(negedge clk);
        checks++; if (count !== 3'd1 || {addr_out, data_out} !== 48'h5A5A0BADF00D || write !== 1'b1) begin
            errors++; $display("FAIL ar_after got count %0d %0h wr %0h exp 1 5a5a0badf00d 1", count, {addr_out, data_out}, write); end
        checks++; if (short_cnt !== s0) begin errors++; $display("FAIL ar_no_short got %0d exp %0d", short_cnt, s0); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

`ifdef BUS_RX_PARITY_EN
    task automatic test_parity();
        flip_idx = 2;
        drive_frame(16'h7777, 32'h88888888, 6, 1'b1);
        flip_idx = -1;
        @(negedge clk);
        checks++; if (err_parity !== 1'b1) begin errors++; $display("FAIL par_pulse got %0h exp 1", err_parity); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL par_count got %0d exp 0", count); end
        drive_frame(16'h7778, 32'h99999999, 6, 1'b0);
        @(negedge clk);
        checks++; if (err_parity !== 1'b0 || count !== 3'd1 || {addr_out, data_out} !== 48'h777899999999) begin
            errors++; $display("FAIL par_clean got perr %0h count %0d %0h exp 0 1 777899999999", err_parity, count, {addr_out, data_out}); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_write_frame();
        test_short_overrun();
        test_fill_drop();
        test_push_pop_full();
        test_async_reset();
`ifdef BUS_RX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
